comp_32_seq: RTL and testbench
==============================

// Module: comp_32_seq
// PURPOSE
//  Multi-cycle sequencer for the processor's 32-bit magnitude compare. Time-multiplexes one
//  SLICE-bit comparator slice MSB-first across the operands, exits early on the first unequal
//  slice, and reports eq/gt with a start/done handshake. Area-saving alternative to the flat
//  comparator for branch (bne/blt) resolution; the pipeline stalls on busy.
// PARAMETERS
//  WIDTH  32  operand width; must be a multiple of SLICE
//  SLICE  2   bits compared per cycle; NSLICE = WIDTH/SLICE slices
// PORTS
//  clock      in   1      single clock, all state on rising edge
//  resetn     in   1      asynchronous, active-low reset
//  start      in   1      request compare; accepted only when busy=0
//  flush      in   1      synchronous abort of an in-flight compare
//  is_signed  in   1      1: two's-complement compare; 0: unsigned; sampled with start
//  in1        in   WIDTH  operand A, sampled on accepted start only
//  in2        in   WIDTH  operand B, sampled on accepted start only
//  busy       out  1      high while a compare is in progress
//  done       out  1      one-cycle pulse: eq_out/gt_out valid and freshly updated
//  eq_out     out  1      A == B
//  gt_out     out  1      A > B (signed or unsigned per latched is_signed)
// BEHAVIOUR
//  - Reset (resetn=0, async): state=IDLE, busy=0, done=0, eq_out=0, gt_out=0, index=0.
//  - FSM states: IDLE, RUN. done is a registered output, not a state.
//  - IDLE: start=1 & flush=0 -> latch a=in1, b=in2; if is_signed invert bit WIDTH-1 of both
//    (offset-binary so unsigned slice compare gives signed order); index=NSLICE-1; -> RUN.
//  - RUN, each edge: compare slice a[index*SLICE +: SLICE] vs b[same].
//    * slice unequal -> eq_out=0, gt_out=slice_gt, done=1, -> IDLE.
//    * slice equal & index==0 -> eq_out=1, gt_out=0, done=1, -> IDLE.
//    * slice equal & index>0 -> index=index-1, stay RUN.
//  - Latency: start sampled at edge T0; result and done visible after edge Tn, n = slices
//    examined (1..NSLICE). Equal operands: n=NSLICE (16 at defaults). busy=1 from after T0 until
//    the edge that raises done; busy=0 in the done cycle.
//  - done is high for exactly one cycle; start in that same cycle is accepted (back-to-back).
//  - eq_out/gt_out change only on a completing edge; held stable otherwise, including across
//    later starts and flushes. eq_out and gt_out are never both 1.
//  - start while busy=1: ignored; latched operands and is_signed unchanged.
//  - flush=1 in RUN: -> IDLE next edge, busy=0, no done, results untouched. flush has priority
//    over completion in the same cycle. flush & start in IDLE: flush wins, start dropped.
//  - resetn asserted mid-compare: immediate return to reset values; no done emitted.
//  - index decrement never wraps: index==0 always terminates RUN.
// STRUCTURE
//  - Shared package: state encoding localparams (ST_IDLE, ST_RUN), NSLICE derivation, and the
//    WIDTH % SLICE == 0 elaboration check.
//  - One sub-module: comp_2 (combinational SLICE-bit slice: in1, in2 -> eq, gt), instantiated
//    once and fed by an index-driven mux on the latched operands.
//  - This module holds the FSM, index counter, operand registers and result registers.
// TESTING
//  - Equal unsigned: in1=in2=32'hDEADBEEF, is_signed=0 -> done after exactly 16 edges, eq=1, gt=0.
//  - MSB early exit: in1=32'h8000_0000, in2=0, is_signed=0 -> done after 1 edge, eq=0, gt=1.
//  - Signed order: in1=32'hFFFF_FFFF (-1), in2=1, is_signed=1 -> gt=0, eq=0; same with
//    is_signed=0 -> gt=1.
//  - LSB difference: in1=5, in2=4 -> done after 16 edges, gt=1; swap operands -> gt=0, eq=0.
//  - Handshake: start held high during busy with new operands -> ignored; start in done cycle ->
//    second compare accepted, results of first held until second done.
//  - Abort: flush at RUN cycle 3 -> busy=0 next cycle, no done, prior eq/gt unchanged; resetn
//    low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/comp_32_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | comp_32_seq_pkg -- shared state encoding and slice-geometry helpers.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package comp_32_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 2;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    function automatic int calc_idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    function automatic bit width_ok(input int width, input int slice);
        return (slice > 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/comp_32_seq_comp_2.sv
// +--------------------------------------------------------------------------+
// | comp_2 -- combinational unsigned SLICE-bit compare slice (eq, gt).       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module comp_2 #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] in1,
    input  logic [SLICE-1:0] in2,
    output logic             eq,
    output logic             gt
);

    assign eq = (in1 == in2);
    assign gt = (in1 > in2);

endmodule

`default_nettype wire

// File: rtl/comp_32_seq.sv
// +--------------------------------------------------------------------------+
// | comp_32_seq -- MSB-first slice-serial magnitude comparator, early exit.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module comp_32_seq
    import comp_32_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             flush,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic             eq_out,
    output logic             gt_out
);

    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDX_W  = calc_idx_w(NSLICE);
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NSLICE - 1);

    if (!width_ok(WIDTH, SLICE)) begin : g_bad_geometry
        $error("comp_32_seq: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           state_q;
    logic [IDX_W-1:0] index_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             gt_q;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic             slice_eq;
    logic             slice_gt;
    logic [WIDTH-1:0] flip_d;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (index_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE +: SLICE];
                slice_b = b_q[i*SLICE +: SLICE];
            end
        end
    end

    comp_2 #(
        .SLICE (SLICE)
    ) u_slice (
        .in1 (slice_a),
        .in2 (slice_b),
        .eq  (slice_eq),
        .gt  (slice_gt)
    );

    // Offset-binary: flipping both sign bits makes unsigned order match signed order.
    assign flip_d = is_signed ? SIGN_MASK : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        a_q     <= in1 ^ flip_d;
                        b_q     <= in2 ^ flip_d;
                        index_q <= IDX_TOP;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!slice_eq) begin
                        eq_q    <= 1'b0;
                        gt_q    <= slice_gt;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (index_q == '0) begin
                        eq_q    <= 1'b1;
                        gt_q    <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        index_q <= index_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign eq_out = eq_q;
    assign gt_out = gt_q;

endmodule

`default_nettype wire

// File: tb/tb_comp_32_seq.sv
// +--------------------------------------------------------------------------+
// | tb_comp_32_seq -- randomized scoreboard bench for comp_32_seq.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_comp_32_seq;

    localparam int W  = 32;
    localparam int SL = 2;
    localparam int NS = W / SL;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic          is_signed = 1'b0;
    logic [W-1:0]  in1 = '0;
    logic [W-1:0]  in2 = '0;
    logic          busy;
    logic          done;
    logic          eq_out;
    logic          gt_out;

    typedef struct {
        bit eq;
        bit gt;
        int t0;
        int n;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   last_eq = 1'b0;
    bit   last_gt = 1'b0;

    comp_32_seq #(
        .WIDTH (W),
        .SLICE (SL)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .flush     (flush),
        .is_signed (is_signed),
        .in1       (in1),
        .in2       (in2),
        .busy      (busy),
        .done      (done),
        .eq_out    (eq_out),
        .gt_out    (gt_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: plain integer compare; latency = slices down to the highest differing bit.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output bit e_eq, output bit e_gt, output int n);
        logic [W-1:0] d;
        bit found;
        e_eq  = (a == b);
        e_gt  = s ? ($signed(a) > $signed(b)) : (a > b);
        d     = a ^ b;
        n     = NS;
        found = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
            if (!found && d[k]) begin
                found = 1'b1;
                n     = NS - (k / SL);
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done, otherwise checks results are held.
    always @(negedge clock) begin
        if (resetn) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending compare (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("eq_out", int'(eq_out), int'(e.eq));
                    check("gt_out", int'(gt_out), int'(e.gt));
                    check("latency", cyc - e.t0, e.n);
                    check("busy_in_done", int'(busy), 0);
                    last_eq = e.eq;
                    last_gt = e.gt;
                end
            end else begin
                check("eq_hold", int'(eq_out), int'(last_eq));
                check("gt_hold", int'(gt_out), int'(last_gt));
            end
        end
    end

    // Call at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        exp_t e;
        in1 = a;
        in2 = b;
        is_signed = s;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        model(a, b, s, e.eq, e.gt, e.n);
        e.t0 = cyc;
        sb.push_back(e);
    endtask

    // Returns at the negedge where done is seen; optional junk starts while busy.
    task automatic wait_done(input bit junk);
        int  k;
        bit  got;
        k   = 0;
        got = 1'b0;
        while (!got && k < 64) begin
            @(negedge clock);
            k++;
            if (done) begin
                got = 1'b1;
            end else begin
                check("busy_run", int'(busy), 1);
                if (junk) begin
                    start     = 1'($urandom_range(0, 1));
                    in1       = $urandom;
                    in2       = $urandom;
                    is_signed = 1'($urandom_range(0, 1));
                end
            end
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 64 cycles");
        end
    endtask

    function automatic logic [W-1:0] rand_partner(input logic [W-1:0] a);
        int sel;
        int pos;
        sel = $urandom_range(0, 3);
        pos = $urandom_range(0, W - 1);
        case (sel)
            0:       return a;
            1:       return a ^ (W'(1) << pos);
            2:       return a ^ (W'($urandom) >> pos);
            default: return W'($urandom);
        endcase
    endfunction

    logic [W-1:0] dir_a [6] = '{32'hDEADBEEF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd4};
    logic [W-1:0] dir_b [6] = '{32'hDEADBEEF, 32'h0, 32'd1, 32'd1, 32'd4, 32'd5};
    bit           dir_s [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        repeat (3) @(negedge clock);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_eq", int'(eq_out), 0);
        check("reset_gt", int'(gt_out), 0);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            issue(dir_a[i], dir_b[i], dir_s[i]);
            wait_done(1'b0);
            @(negedge clock);
        end

        // Busy-time start with new operands is ignored; back-to-back start in done cycle.
        issue(32'h1234_5678, 32'h1234_5678, 1'b0);
        wait_done(1'b1);
        issue(32'h0000_0001, 32'h0000_0002, 1'b1);
        wait_done(1'b1);
        @(negedge clock);

        // Flush at RUN cycle 3: no done, busy drops, results untouched.
        issue(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
        repeat (3) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        void'(sb.pop_back());
        @(negedge clock);
        check("flush_busy", int'(busy), 0);
        check("flush_done", int'(done), 0);

        // flush together with start in IDLE drops the start.
        start = 1'b1;
        flush = 1'b1;
        in1   = 32'h1;
        in2   = 32'h2;
        @(posedge clock);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clock);
        check("flush_start_busy", int'(busy), 0);
        repeat (3) @(negedge clock);

        // Randomized traffic with mixed gaps and back-to-back issue.
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a;
            a = $urandom;
            issue(a, rand_partner(a), 1'($urandom_range(0, 1)));
            wait_done(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
        end

        // Async reset mid-compare after an eq=1 result.
        issue(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0);
        wait_done(1'b0);
        @(negedge clock);
        issue(32'h0000_00FF, 32'h0000_00FF, 1'b0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2;
        sb.delete();
        last_eq = 1'b0;
        last_gt = 1'b0;
        resetn  = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_eq", int'(eq_out), 0);
        check("rst_gt", int'(gt_out), 0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        check("post_rst_busy", int'(busy), 0);

        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        wait_done(1'b0);
        @(negedge clock);
        check("queue_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
